// File: rtl/riscv_icache_refill.sv
// Direct-mapped instruction cache with an in-order line refill engine.
// Hits answer one cycle after acceptance; misses fetch a whole line from backing memory, then answer.
module riscv_icache_refill #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // LINES and WORDS are expected to be powers of two, WORDS >= 2.
    localparam int OFF_W   = $clog2(WORDS);
    localparam int IDX_W   = $clog2(LINES);
    localparam int IDX_LSB = 2 + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESPOND
    } state_t;

    state_t state;
    state_t next_state;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][WORDS];

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;

    logic [OFF_W-1:0] off_q;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;
    logic [OFF_W-1:0] beat;
    logic [31:0]      crit_word;

    logic hit;
    logic take_hit;
    logic take_miss;
    logic beat_fire;
    logic last_beat;

    logic unused_addr_bits;

    assign req_off = req_addr[IDX_LSB-1:2];
    assign req_idx = req_addr[TAG_LSB-1:IDX_LSB];
    assign req_tag = req_addr[31:TAG_LSB];

    assign unused_addr_bits = ^req_addr[1:0];

    assign busy = (state != IDLE) || flush;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        hit        = valid[req_idx] && (tag_mem[req_idx] == req_tag);
        next_state = state;
        take_hit   = 1'b0;
        take_miss  = 1'b0;
        beat_fire  = 1'b0;
        last_beat  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && !flush) begin
                    if (hit) begin
                        take_hit = 1'b1;
                    end else begin
                        take_miss  = 1'b1;
                        next_state = REFILL;
                    end
                end
            end
            REFILL: begin
                if (mem_req && mem_ack) begin
                    beat_fire = 1'b1;
                    if (beat == LAST_BEAT) begin
                        last_beat  = 1'b1;
                        next_state = RESPOND;
                    end
                end
            end
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Control and output registers; the last refill beat also produces the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            beat       <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_inst  <= '0;
            off_q      <= '0;
            idx_q      <= '0;
            tag_q      <= '0;
            crit_word  <= '0;
        end else begin
            resp_valid <= 1'b0;

            if (state == IDLE && flush) begin
                valid <= '0;
            end

            if (take_hit) begin
                resp_valid <= 1'b1;
                resp_inst  <= data_mem[req_idx][req_off];
            end

            if (take_miss) begin
                off_q    <= req_off;
                idx_q    <= req_idx;
                tag_q    <= req_tag;
                beat     <= '0;
                mem_req  <= 1'b1;
                mem_addr <= {req_addr[31:IDX_LSB], {IDX_LSB{1'b0}}};
            end

            if (beat_fire) begin
                beat     <= beat + 1'b1;
                mem_addr <= mem_addr + 32'd4;
                if (beat == off_q) begin
                    crit_word <= mem_rdata;
                end
            end

            if (last_beat) begin
                valid[idx_q] <= 1'b1;
                mem_req      <= 1'b0;
                resp_valid   <= 1'b1;
                resp_inst    <= (off_q == LAST_BEAT) ? mem_rdata : crit_word;
            end
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone decide whether their contents count.
    always_ff @(posedge clk) begin
        if (!rst && beat_fire) begin
            data_mem[idx_q][beat] <= mem_rdata;
            if (last_beat) begin
                tag_mem[idx_q] <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_riscv_icache_refill.sv
// Scoreboard bench for riscv_icache_refill: directed scenarios followed by randomized requests,
// checked against a line-level cache model and a static backing-memory image.
module tb_riscv_icache_refill;

    localparam int LINES      = 16;
    localparam int WORDS      = 4;
    localparam int LINE_BYTES = WORDS * 4;
    localparam int IDX_LSB    = 2 + $clog2(WORDS);
    localparam int TAG_LSB    = IDX_LSB + $clog2(LINES);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    riscv_icache_refill #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .flush     (flush),
        .resp_valid(resp_valid),
        .resp_inst (resp_inst),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: which tag each line holds, and the expected-response queue.
    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    logic [31:0] sb[$];

    // Driver-owned knobs read by the memory responder.
    int          req_seq       = 0;
    bit          expect_refill = 1'b0;
    logic [31:0] exp_base      = '0;
    bit          ack_random    = 1'b0;
    int          stall_beat    = 0;
    int          stall_cfg     = 0;

    // Responder-owned counters.
    int beats_done    = 0;
    int refill_cycles = 0;

    // Monitor-owned.
    int resp_count = 0;
    int resp_cyc   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    endtask

    function automatic logic [31:0] backing(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_0011;
            32'h0000_0104: return 32'h0000_0022;
            32'h0000_0108: return 32'h0000_0033;
            32'h0000_010C: return 32'h0000_0044;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Backing memory: answers reads, checks the address sequence, optionally stalls.
    initial begin
        int seen_seq   = 0;
        int stall_left = 0;
        bit ack;
        forever begin
            @(negedge clk);
            if (req_seq != seen_seq) begin
                seen_seq      = req_seq;
                beats_done    = 0;
                refill_cycles = 0;
                stall_left    = stall_cfg;
            end
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                refill_cycles++;
                if (!expect_refill) begin
                    check("mem_req_unexpected", 32'(mem_req), 32'(expect_refill));
                end else begin
                    check("mem_addr", mem_addr, exp_base + 32'(4 * beats_done));
                    check("busy_refill", 32'(busy), 32'd1);
                end
                if (beats_done == stall_beat && stall_left > 0) begin
                    stall_left--;
                    ack = 1'b0;
                end else begin
                    ack = ack_random ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                mem_ack   = ack;
                mem_rdata = backing(mem_addr);
                if (ack) beats_done++;
            end
        end
    end

    // Response monitor: pops the scoreboard on every resp_valid pulse.
    initial begin
        logic [31:0] last_inst  = '0;
        bit          prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                last_inst  = '0;
                prev_valid = 1'b0;
            end else begin
                if (resp_valid) begin
                    resp_count++;
                    resp_cyc = cyc;
                    check("resp_single_pulse", 32'(prev_valid), 32'd0);
                    if (sb.size() == 0) check("resp_unexpected", resp_inst, 32'hDEAD_BEEF);
                    else check("resp_inst", resp_inst, sb.pop_front());
                    last_inst = resp_inst;
                end else begin
                    check("resp_hold", resp_inst, last_inst);
                end
                prev_valid = resp_valid;
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic [31:0] addr, input bit exact_timing);
        int unsigned idx;
        int unsigned tag;
        bit          hit;
        int          start_cnt;
        int          c0;
        bit          got = 1'b0;
        wait_idle();
        idx = (addr >> IDX_LSB) % LINES;
        tag = addr >> TAG_LSB;
        hit = m_valid[idx] && (m_tag[idx] == tag);
        expect_refill = !hit;
        exp_base      = addr & ~32'(LINE_BYTES - 1);
        req_seq++;
        sb.push_back(backing(addr & ~32'd3));
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        start_cnt    = resp_count;
        c0           = cyc + 1;
        req_valid    = 1'b1;
        req_addr     = addr;
        @(negedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        for (int i = 0; i < 300; i++) begin
            if (resp_count != start_cnt) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        if (!got) begin
            check("resp_timeout", 32'(resp_count), 32'(start_cnt + 1));
            return;
        end
        check("resp_latency", 32'(resp_cyc), 32'(c0 + (hit ? 0 : refill_cycles)));
        if (!hit) check("refill_beats", 32'(beats_done), 32'(WORDS));
        if (exact_timing && !hit) check("refill_cycles", 32'(refill_cycles), 32'(WORDS + stall_cfg));
    endtask

    task automatic do_flush(input bit with_req, input logic [31:0] addr);
        int start_cnt;
        wait_idle();
        expect_refill = 1'b0;
        start_cnt = resp_count;
        flush     = 1'b1;
        req_valid = with_req;
        req_addr  = addr;
        #1;
        check("busy_flush", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check("flush_dropped", 32'(resp_count), 32'(start_cnt));
    endtask

    task automatic reset_mid_refill(input logic [31:0] addr);
        int  start_cnt;
        bit  ok = 1'b0;
        wait_idle();
        expect_refill = 1'b1;
        exp_base      = addr & ~32'(LINE_BYTES - 1);
        req_seq++;
        start_cnt = resp_count;
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (beats_done == 2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("beat2_timeout", 32'(beats_done), 32'd2);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        expect_refill = 1'b0;
        model_clear();
        repeat (6) @(negedge clk);
        check("rst_mid_no_resp", 32'(resp_count), 32'(start_cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          tags [4] = '{0, 1, 2, 32'h000A_BCDE};
        model_clear();

        // Two reset cycles.
        repeat (2) @(negedge clk);
        #1;
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_resp_inst", resp_inst, 32'h0);
        rst = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);

        issue(32'h0000_0104, 1'b1);
        issue(32'h0000_0108, 1'b1);
        issue(32'h0000_0204, 1'b1);

        stall_beat = 1;
        stall_cfg  = 3;
        issue(32'h0000_0104, 1'b1);
        stall_cfg  = 0;

        do_flush(1'b1, 32'h0000_0104);
        issue(32'h0000_0104, 1'b1);

        reset_mid_refill(32'h0000_0304);
        issue(32'h0000_0104, 1'b1);
        issue(32'h0000_0304, 1'b1);
        issue(32'h0000_010F, 1'b1);

        ack_random = 1'b1;
        for (int n = 0; n < 160; n++) begin
            a = (32'(tags[$urandom_range(0, 3)]) << TAG_LSB)
              | (32'($urandom_range(0, LINES - 1)) << IDX_LSB)
              | (32'($urandom_range(0, WORDS - 1)) << 2)
              | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) do_flush(1'($urandom_range(0, 1)), a);
            else issue(a, 1'b0);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
